ifu_fetch: RTL and testbench

IFU_FETCH -- requirements
Module: ifu_fetch

---
 rtl/ifu_fetch.sv | 113 +++++++++++
 tb/tb_ifu_fetch.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one-outstanding-request fetcher feeding a 2-entry
// instruction buffer, with redirect flush, sticky halt and fault tagging.
module ifu_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        halt,
  output logic        mem_req_valid,
  output logic [63:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        mem_rsp_err,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [63:0] instr_pc,
  input  logic        instr_ready,
  output logic        fetch_err
);

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, HALT} state_t;

  state_t      state_q, state_d;
  logic [63:0] fetch_pc;
  logic [63:0] req_pc;
  logic        outstanding;
  logic        drop;
  logic [1:0]  fifo_cnt;
  logic        wr_ptr, rd_ptr;
  logic [31:0] fifo_instr [2];
  logic [63:0] fifo_pc    [2];
  logic        fifo_err   [2];

  logic can_issue, hs, rsp_fire, redir, push, pop;

  // A faulted fetch is handed to decode as a harmless addi x0,x0,0.
  function automatic logic [31:0] head_word(input logic err, input logic [31:0] word);
    return err ? NOP_WORD : word;
  endfunction

  assign can_issue     = ({1'b0, fifo_cnt} + {2'b00, outstanding}) < 3'd2;
  assign mem_req_valid = (state_q == FETCH) && can_issue && !halt;
  assign hs            = mem_req_valid && mem_req_ready;
  assign rsp_fire      = mem_rsp_valid && outstanding;
  assign redir         = redirect_valid && !halt && (state_q != HALT);
  assign push          = rsp_fire && !drop && !redir;
  assign pop           = instr_valid && instr_ready;

  always_comb begin
    state_d = state_q;
    if (halt || state_q == HALT) begin
      state_d = HALT;
    end else begin
      case (state_q)
        IDLE:    state_d = FETCH;
        FETCH:   if (hs) state_d = WAIT;
        WAIT:    if (rsp_fire) state_d = FETCH;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      fetch_pc    <= RESET_PC;
      outstanding <= 1'b0;
      drop        <= 1'b0;
      fifo_cnt    <= 2'd0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (redir)   fetch_pc <= redirect_pc & ~64'd3;
      else if (hs) fetch_pc <= fetch_pc + 64'd4;
      if (hs)            outstanding <= 1'b1;
      else if (rsp_fire) outstanding <= 1'b0;
      // Whatever is in flight across a redirect belongs to the old path.
      if (redir)         drop <= hs || (outstanding && !rsp_fire);
      else if (rsp_fire) drop <= 1'b0;
      if (redir) begin
        fifo_cnt <= 2'd0;
        wr_ptr   <= 1'b0;
        rd_ptr   <= 1'b0;
      end else begin
        if (push) wr_ptr <= ~wr_ptr;
        if (pop)  rd_ptr <= ~rd_ptr;
        fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (hs) req_pc <= fetch_pc;
    if (push) begin
      fifo_instr[wr_ptr] <= mem_rsp_data;
      fifo_pc[wr_ptr]    <= req_pc;
      fifo_err[wr_ptr]   <= mem_rsp_err;
    end
  end

  assign mem_req_addr = mem_req_valid ? fetch_pc : 64'd0;
  assign instr_valid  = (fifo_cnt != 2'd0);
  assign instr        = instr_valid ? head_word(fifo_err[rd_ptr], fifo_instr[rd_ptr]) : 32'd0;
  assign instr_pc     = instr_valid ? fifo_pc[rd_ptr] : 64'd0;
  assign fetch_err    = instr_valid && fifo_err[rd_ptr];

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: bench-side memory, queue-based reference of the fetch
// stream, directed scenarios V1-V6 followed by a randomized run.
module tb_ifu_fetch;
  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halt;
  logic        mem_req_valid;
  logic [63:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_err;
  logic        instr_valid;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        instr_ready;
  logic        fetch_err;

  always #5 clk = ~clk;

  ifu_fetch #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .fetch_err(fetch_err)
  );

  typedef struct {
    logic [31:0] data;
    logic [63:0] pc;
    logic        err;
  } ent_t;

  int          checks = 0;
  int          errors = 0;
  ent_t        q[$];
  logic [63:0] hs_log[$];
  logic [63:0] pop_pc[$];
  logic [31:0] pop_instr[$];
  logic        pop_err[$];
  bit          started, halted, pending, pend_drop, pend_err, stale, rand_err;
  int          pend_wait, lat_min, lat_max;
  logic [63:0] exp_pc, pend_addr, force_err_addr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req_valid"}, mem_req_valid, 0);
    chk({tag, "_req_addr"}, mem_req_addr, 0);
    chk({tag, "_instr_valid"}, instr_valid, 0);
    chk({tag, "_instr"}, instr, 0);
    chk({tag, "_instr_pc"}, instr_pc, 0);
    chk({tag, "_fetch_err"}, fetch_err, 0);
  endtask

  task automatic model_clear();
    redirect_valid = 0; redirect_pc = 0; halt = 0; instr_ready = 1; mem_req_ready = 1;
    mem_rsp_valid = 0; mem_rsp_data = 0; mem_rsp_err = 0;
    q.delete(); hs_log.delete(); pop_pc.delete(); pop_instr.delete(); pop_err.delete();
    pending = 0; pend_drop = 0; pend_err = 0; pend_wait = 0; pend_addr = 0;
    started = 0; halted = 0; stale = 0; rand_err = 0;
    exp_pc = RST_PC; force_err_addr = '1; lat_min = 1; lat_max = 1;
  endtask

  task automatic do_reset();
    rst = 0;
    model_clear();
    @(negedge clk);
    #1 chk_zero("reset");
    @(negedge clk);
    rst = 1;
  endtask

  // One clock cycle: present memory response, check outputs against the
  // reference, advance the reference across the coming edge.
  task automatic step();
    bit rsp, fire, redir, exp_rv;
    ent_t e;
    rsp           = pending && (pend_wait == 0);
    mem_rsp_valid = rsp || stale;
    mem_rsp_data  = pend_addr[31:0] ^ 32'h3c5a_0f00;
    mem_rsp_err   = pend_err;
    #1;
    exp_rv = started && !halted && !halt && !pending && (q.size() < 2);
    chk("req_valid", mem_req_valid, exp_rv);
    if (exp_rv) chk("req_addr", mem_req_addr, exp_pc);
    chk("instr_valid", instr_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("instr", instr, q[0].err ? 32'h0000_0013 : q[0].data);
      chk("instr_pc", instr_pc, q[0].pc);
      chk("fetch_err", fetch_err, q[0].err);
    end
    fire  = mem_req_valid && mem_req_ready;
    redir = redirect_valid && !halt && !halted;
    if (instr_valid && instr_ready) begin
      pop_pc.push_back(instr_pc); pop_instr.push_back(instr); pop_err.push_back(fetch_err);
      if (q.size() != 0) void'(q.pop_front());
    end
    if (rsp) begin
      if (!pend_drop && !redir) begin
        e.data = mem_rsp_data; e.pc = pend_addr; e.err = pend_err;
        q.push_back(e);
      end
      pending = 0;
    end else if (pending) begin
      pend_wait--;
    end
    if (redir) begin
      q.delete();
      exp_pc    = {redirect_pc[63:2], 2'b00};
      pend_drop = 1;
    end else if (fire) begin
      exp_pc = exp_pc + 64'd4;
    end
    if (fire) begin
      hs_log.push_back(mem_req_addr);
      pending   = 1;
      pend_addr = mem_req_addr;
      pend_drop = redir;
      pend_err  = (mem_req_addr == force_err_addr) || (rand_err && ($urandom % 8 == 0));
      pend_wait = $urandom_range(lat_max, lat_min) - 1;
    end
    if (halt) halted = 1;
    started = 1;
    stale   = 0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_hs(output logic [63:0] a);
    int n;
    bit ok;
    ok = 0;
    a  = '1;
    for (int i = 0; i < 40 && !ok; i++) begin
      n = hs_log.size();
      step();
      if (hs_log.size() > n) begin
        ok = 1;
        a  = hs_log[$];
      end
    end
    chk("hs_seen", ok, 1);
  endtask

  initial begin
    logic [63:0] a;
    int n, k, hits;
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    logic [63:0] a;
    int n, k, hits;

    // V1: streaming fetch, 1-cycle memory, decode always ready
    do_reset();
    repeat (12) step();
    chk("v1_hs0", hs_log[0], 64'h8000_0000);
    chk("v1_hs1", hs_log[1], 64'h8000_0004);
    chk("v1_hs2", hs_log[2], 64'h8000_0008);
    chk("v1_pop0", pop_pc[0], 64'h8000_0000);
    chk("v1_pop1", pop_pc[1], 64'h8000_0004);
    chk("v1_pop2", pop_pc[2], 64'h8000_0008);
    chk("v1_rate", pop_pc.size(), 5);

    // V2: decode stalled, buffer fills, then resumes
    do_reset();
    instr_ready = 0;
    repeat (10) step();
    chk("v2_hs_count", hs_log.size(), 2);
    chk("v2_head_valid", instr_valid, 1);
    chk("v2_head_pc", instr_pc, 64'h8000_0000);
    instr_ready = 1;
    wait_hs(a);
    chk("v2_resume_addr", a, 64'h8000_0008);

    // V3: redirect while a request is outstanding
    do_reset();
    lat_min = 3; lat_max = 3;
    a = 0;
    for (int i = 0; i < 8 && a != 64'h8000_0010; i++) wait_hs(a);
    chk("v3_reach_0x10", a, 64'h8000_0010);
    redirect_valid = 1; redirect_pc = 64'h8000_0103;
    step();
    redirect_valid = 0;
    chk("v3_flushed", instr_valid, 0);
    wait_hs(a);
    chk("v3_new_addr", a, 64'h8000_0100);
    repeat (6) step();
    hits = 0;
    foreach (pop_pc[i]) if (pop_pc[i] == 64'h8000_0010) hits++;
    chk("v3_dropped", hits, 0);

    // V4: access fault on the second fetch
    do_reset();
    force_err_addr = 64'h8000_0004;
    repeat (10) step();
    chk("v4_pc1", pop_pc[1], 64'h8000_0004);
    chk("v4_nop", pop_instr[1], 32'h0000_0013);
    chk("v4_err1", pop_err[1], 1);
    chk("v4_err0", pop_err[0], 0);
    chk("v4_err2", pop_err[2], 0);

    // V5: halt with one entry buffered and one request in flight
    do_reset();
    lat_min = 2; lat_max = 2; instr_ready = 0;
    wait_hs(a);
    wait_hs(a);
    chk("v5_setup_addr", a, 64'h8000_0004);
    chk("v5_setup_valid", instr_valid, 1);
    halt = 1;
    step();
    halt = 0;
    n = hs_log.size(); k = pop_pc.size();
    instr_ready = 1;
    repeat (3) step();
    redirect_valid = 1; redirect_pc = 64'h0000_0000_0000_1234;
    step();
    redirect_valid = 0;
    repeat (6) step();
    chk("v5_no_req", hs_log.size(), n);
    chk("v5_drained", pop_pc.size() - k, 2);
    chk("v5_pop_a", pop_pc[k], 64'h8000_0000);
    chk("v5_pop_b", pop_pc[k + 1], 64'h8000_0004);
    chk("v5_empty", instr_valid, 0);

    // V6: reset asserted while waiting on memory
    do_reset();
    lat_min = 3; lat_max = 3; instr_ready = 0;
    wait_hs(a);
    wait_hs(a);
    chk("v6_pre_valid", instr_valid, 1);
    #2 rst = 0;
    #1 chk_zero("v6");
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst   = 1;
    stale = 1;
    wait_hs(a);
    chk("v6_first_addr", a, RST_PC);
    repeat (8) step();

    // Randomized traffic with redirects (including near the 64-bit wrap)
    do_reset();
    lat_min = 1; lat_max = 3; rand_err = 1;
    for (int i = 0; i < 600; i++) begin
      mem_req_ready  = ($urandom % 4) != 0;
      instr_ready    = ($urandom % 3) != 0;
      redirect_valid = ($urandom % 16) == 0;
      redirect_pc    = ($urandom % 4 == 0) ? 64'hFFFF_FFFF_FFFF_FFF9 : {$urandom, $urandom};
      step();
    end
    redirect_valid = 0;
    chk("rand_activity", hs_log.size() > 50, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
